spi_request_scheduler: RTL

Arbitrates up to three client requesters onto the single SPI `Master` and sequences each 8-bit full-duplex transfer. It selects a requester round-robin and drives `start`, `slaveSelect` and `masterDataToSend` into the `Master`. After a fixed transfer window it captures `masterDataReceived` and returns it to the winning requester with a one-cycle completion pulse. It sits between the client logic and the `Master`, which otherwise has no notion of multiple users.

---
 rtl/spi_pkg.sv | 16 +
 rtl/spi_rr_arbiter.sv | 30 +++
 rtl/spi_request_scheduler.sv | 114 +++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI request scheduler slice.
package spi_pkg;

    localparam int SPI_DATA_WIDTH  = 8;
    localparam int SPI_NUM_SLAVES  = 3;
    localparam int SPI_XFER_CYCLES = 9;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } spi_state_t;

endpackage

// File: rtl/spi_rr_arbiter.sv
// Combinational round-robin pick: search starts at ptr and wraps upward.
module spi_rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gntIdx
);

    logic found;
    int   idx;

    always_comb begin
        gnt    = '0;
        gntIdx = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gntIdx   = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/spi_request_scheduler.sv
// Arbitrates requesters onto the single SPI Master and sequences one
// full-duplex transfer per grant, returning the RX byte with a done pulse.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for any req; arbiter winner latched on exit
// ST_LOAD  | slave index and TX byte registered toward the Master
// ST_START | start pulse high; wait counter loaded
// ST_WAIT  | counter runs down; RX byte captured when it reaches zero
// ST_DONE  | done pulse to the winner; priority pointer advances
module spi_request_scheduler
    import spi_pkg::*;
#(
    parameter int NUM_REQ     = SPI_NUM_SLAVES,
    parameter int DATA_WIDTH  = SPI_DATA_WIDTH,
    parameter int XFER_CYCLES = SPI_XFER_CYCLES
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] reqData,
    output logic [NUM_REQ-1:0]            done,
    output logic [DATA_WIDTH-1:0]         rxData,
    output logic                          busy,
    output logic                          start,
    output logic [1:0]                    slaveSelect,
    output logic [DATA_WIDTH-1:0]         masterDataToSend,
    input  logic [DATA_WIDTH-1:0]         masterDataReceived
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(XFER_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(XFER_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

    spi_state_t         state;
    spi_state_t         state_next;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   gnt_idx_q;
    logic [CNT_W-1:0]   cnt;
    logic [NUM_REQ-1:0] arb_gnt;
    logic [IDX_W-1:0]   arb_idx;
    logic               gnt_any;
    logic [NUM_REQ-1:0] done_vec;

    spi_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req    (req),
        .ptr    (ptr),
        .gnt    (arb_gnt),
        .gntIdx (arb_idx)
    );

    assign gnt_any  = |arb_gnt;
    assign done_vec = NUM_REQ'(1) << gnt_idx_q;

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (gnt_any) state_next = ST_LOAD;
            ST_LOAD:  state_next = ST_START;
            ST_START: state_next = ST_WAIT;
            ST_WAIT:  if (cnt == '0) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= ST_IDLE;
            ptr              <= '0;
            gnt_idx_q        <= '0;
            cnt              <= '0;
            start            <= 1'b0;
            busy             <= 1'b0;
            done             <= '0;
            slaveSelect      <= '0;
            masterDataToSend <= '0;
            rxData           <= '0;
        end else begin
            state <= state_next;
            // Outputs are registered from the next state so they line up
            // with the state they describe.
            start <= (state_next == ST_START);
            busy  <= (state_next != ST_IDLE);
            done  <= (state_next == ST_DONE) ? done_vec : '0;

            case (state)
                ST_IDLE: begin
                    if (gnt_any) gnt_idx_q <= arb_idx;
                end
                ST_LOAD: begin
                    slaveSelect      <= 2'(gnt_idx_q);
                    masterDataToSend <= reqData[int'(gnt_idx_q)*DATA_WIDTH +: DATA_WIDTH];
                end
                ST_START: begin
                    cnt <= CNT_LOAD;
                end
                ST_WAIT: begin
                    if (cnt != '0) cnt <= cnt - 1'b1;
                    else           rxData <= masterDataReceived;
                end
                ST_DONE: begin
                    ptr <= (gnt_idx_q == IDX_LAST) ? '0 : gnt_idx_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
